// File: rtl/eq_pkg.sv
// Shared constants and types for the equalizer gain scheduler.
//   NBANDS / W / ACC_W : band count, sample width, accumulator width
//   IDX_W              : width of the band index counter
//   GAIN_*             : 2-bit gain select codes understood by ampl_2bit
//   state_t            : scheduler FSM encoding
//   ACC_MAX / ACC_MIN  : signed W-bit limits expressed at accumulator width
package eq_pkg;
  localparam int NBANDS = 5;
  localparam int W      = 16;
  localparam int ACC_W  = 19;
  localparam int IDX_W  = $clog2(NBANDS);

  localparam logic [1:0] GAIN_X1   = 2'b00;
  localparam logic [1:0] GAIN_X2   = 2'b01;
  localparam logic [1:0] GAIN_X4   = 2'b10;
  localparam logic [1:0] GAIN_DIV4 = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic signed [ACC_W-1:0] ACC_MAX = ACC_W'((1 << (W-1)) - 1);
  localparam logic signed [ACC_W-1:0] ACC_MIN = -ACC_MAX - ACC_W'(1);
endpackage

// File: rtl/band_gain_sched_if.sv
// Bus between the FIR bank / audio path and band_gain_sched.
// Handshake: a sample transfers on a rising clock edge where i_valid and
// o_ready are both high. i_valid while o_ready is low is not stalled; that
// sample is dropped and counted in o_drop_cnt. o_valid is a one-cycle pulse
// with no back-pressure; o_mix/o_sat hold their value until the next result.
//   i_valid/i_bands   : sample strobe and packed band samples (band k at [k*W +: W])
//   i_cfg_we/i_cfg    : gain config write strobe and packed 2-bit gain selects
//   o_ready           : block idle, a new sample will be accepted
//   o_valid/o_mix/o_sat : result pulse, saturated mix, clip flag
//   o_drop_cnt        : saturating overrun counter
//   o_state           : FSM state for observation
interface band_gain_sched_if;
  import eq_pkg::*;

  logic                  i_valid;
  logic [NBANDS*W-1:0]   i_bands;
  logic                  i_cfg_we;
  logic [2*NBANDS-1:0]   i_cfg;
  logic                  o_ready;
  logic                  o_valid;
  logic [W-1:0]          o_mix;
  logic                  o_sat;
  logic [7:0]            o_drop_cnt;
  state_t                o_state;

  modport slave (
    input  i_valid, i_bands, i_cfg_we, i_cfg,
    output o_ready, o_valid, o_mix, o_sat, o_drop_cnt, o_state
  );

  modport master (
    output i_valid, i_bands, i_cfg_we, i_cfg,
    input  o_ready, o_valid, o_mix, o_sat, o_drop_cnt, o_state
  );
endinterface

// File: rtl/band_gain_sched_ampl_2bit.sv
// ampl_2bit: combinational 2-bit gain stage shared by all bands.
//   i_x    : signed W-bit sample
//   i_gain : gain code (x1, x2, x4, /4)
//   o_y    : scaled sample; x2/x4 wrap (MSBs discarded), /4 floors toward -inf
module ampl_2bit
  import eq_pkg::*;
(
  input  logic signed [W-1:0] i_x,
  input  logic [1:0]          i_gain,
  output logic signed [W-1:0] o_y
);

  always_comb begin
    o_y = i_x;
    case (i_gain)
      GAIN_X1:   o_y = i_x;
      GAIN_X2:   o_y = {i_x[W-2:0], 1'b0};
      GAIN_X4:   o_y = {i_x[W-3:0], 2'b00};
      GAIN_DIV4: o_y = i_x >>> 2;
      default:   o_y = i_x;
    endcase
  end

endmodule

// File: rtl/band_gain_sched.sv
// band_gain_sched: schedules one shared ampl_2bit across NBANDS band samples,
// accumulates the scaled bands and saturates the sum to W bits.
//   i_clk   : system clock
//   i_rst_n : asynchronous active-low reset
//   bus     : sample/config inputs and result/status outputs (slave modport)
// Flow: IDLE accepts a sample (snapshot of bands + active config), RUN adds one
// band per cycle, DONE saturates and registers the result, back to IDLE.
module band_gain_sched
  import eq_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_rst_n,
  band_gain_sched_if.slave   bus
);

  state_t                     r_state;
  state_t                     w_next;

  logic [2*NBANDS-1:0]        r_cfg;
  logic [2*NBANDS-1:0]        r_shadow;
  logic [NBANDS*W-1:0]        r_bands;
  logic signed [ACC_W-1:0]    r_acc;
  logic [IDX_W-1:0]           r_idx;
  logic                       r_valid;
  logic [W-1:0]               r_mix;
  logic                       r_sat;
  logic [7:0]                 r_drop;

  logic                       w_ready;
  logic                       w_accept;
  logic                       w_step;
  logic                       w_finish;
  logic                       w_drop;
  logic signed [W-1:0]        w_band;
  logic [1:0]                 w_gain;
  logic signed [W-1:0]        w_amp;
  logic [W-1:0]               w_sat_mix;
  logic                       w_sat_flag;

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (bus.i_valid) w_next = RUN;
      RUN:     if (r_idx == IDX_W'(NBANDS-1)) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // FSM-derived controls
  always_comb begin
    w_ready  = (r_state == IDLE);
    w_accept = w_ready & bus.i_valid;
    w_step   = (r_state == RUN);
    w_finish = (r_state == DONE);
    w_drop   = bus.i_valid & ~w_ready;
  end

  // Band mux from the snapshot; gain comes from the shadow config so that
  // config writes during a sample only take effect on the next one.
  always_comb begin
    w_band = '0;
    w_gain = GAIN_X1;
    for (int k = 0; k < NBANDS; k++) begin
      if (r_idx == IDX_W'(k)) begin
        w_band = r_bands[k*W +: W];
        w_gain = r_shadow[2*k +: 2];
      end
    end
  end

  ampl_2bit u_ampl (
    .i_x    (w_band),
    .i_gain (w_gain),
    .o_y    (w_amp)
  );

  // Saturation of the finished accumulator to W bits
  always_comb begin
    w_sat_mix  = r_acc[W-1:0];
    w_sat_flag = 1'b0;
    if (r_acc > ACC_MAX) begin
      w_sat_mix  = {1'b0, {(W-1){1'b1}}};
      w_sat_flag = 1'b1;
    end else if (r_acc < ACC_MIN) begin
      w_sat_mix  = {1'b1, {(W-1){1'b0}}};
      w_sat_flag = 1'b1;
    end
  end

  // Datapath and status registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cfg    <= '0;
      r_shadow <= '0;
      r_bands  <= '0;
      r_acc    <= '0;
      r_idx    <= '0;
      r_valid  <= 1'b0;
      r_mix    <= '0;
      r_sat    <= 1'b0;
      r_drop   <= '0;
    end else begin
      r_valid <= w_finish;
      // The snapshot below samples r_cfg before this write lands, so a
      // simultaneous write and accept uses the old config.
      if (bus.i_cfg_we) r_cfg <= bus.i_cfg;
      if (w_accept) begin
        r_shadow <= r_cfg;
        r_bands  <= bus.i_bands;
        r_acc    <= '0;
        r_idx    <= '0;
      end
      if (w_step) begin
        r_acc <= r_acc + {{(ACC_W-W){w_amp[W-1]}}, w_amp};
        r_idx <= r_idx + IDX_W'(1);
      end
      if (w_finish) begin
        r_mix <= w_sat_mix;
        r_sat <= w_sat_flag;
      end
      if (w_drop && (r_drop != 8'hFF)) r_drop <= r_drop + 8'd1;
    end
  end

  assign bus.o_ready    = w_ready;
  assign bus.o_valid    = r_valid;
  assign bus.o_mix      = r_mix;
  assign bus.o_sat      = r_sat;
  assign bus.o_drop_cnt = r_drop;
  assign bus.o_state    = r_state;

endmodule

// File: tb/tb_band_gain_sched.sv
// Directed testbench for band_gain_sched: the driver pushes hand-computed
// results into a queue, a monitor pops and compares on every o_valid pulse,
// including the accept-to-result latency.
module tb_band_gain_sched;
  import eq_pkg::*;

  logic i_clk;
  logic i_rst_n;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  logic [16:0] exp_q[$];   // {sat, mix}
  int          lat_q[$];   // cycle index at which o_valid is expected

  band_gain_sched_if bus ();

  band_gain_sched dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .bus     (bus.slave)
  );

  // Clock / reset block
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [79:0] pack5(input int a, input int b, input int c, input int d, input int e);
    return {16'(e), 16'(d), 16'(c), 16'(b), 16'(a)};
  endfunction

  // Monitor / scoreboard
  always @(negedge i_clk) begin
    if (i_rst_n && bus.o_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got o_valid=1 mix=%0h required no result", bus.o_mix);
      end else begin
        logic [16:0] e;
        int          l;
        e = exp_q.pop_front();
        l = lat_q.pop_front();
        check("mix", 32'(bus.o_mix), 32'(e[15:0]));
        check("sat", 32'(bus.o_sat), 32'(e[16]));
        check("latency_cycle", 32'(cyc), 32'(l));
      end
    end
  end

  // Driver tasks
  task automatic send(input logic [79:0] b, input logic [15:0] mix, input logic sat,
                      input int hold, input bit push);
    @(negedge i_clk);
    bus.i_valid = 1'b1;
    bus.i_bands = b;
    if (push) begin
      exp_q.push_back({sat, mix});
      lat_q.push_back(cyc + 7);
    end
    repeat (hold) @(posedge i_clk);
    #1 bus.i_valid = 1'b0;
  endtask

  task automatic write_cfg(input logic [9:0] c);
    @(negedge i_clk);
    bus.i_cfg_we = 1'b1;
    bus.i_cfg    = c;
    @(posedge i_clk);
    #1 bus.i_cfg_we = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(negedge i_clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending results required 0", exp_q.size());
      exp_q.delete();
      lat_q.delete();
    end
    @(negedge i_clk);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ready"}, 32'(bus.o_ready), 32'd1);
    check({tag, "_valid"}, 32'(bus.o_valid), 32'd0);
    check({tag, "_mix"},   32'(bus.o_mix),   32'd0);
    check({tag, "_sat"},   32'(bus.o_sat),   32'd0);
    check({tag, "_drop"},  32'(bus.o_drop_cnt), 32'd0);
    check({tag, "_state"}, 32'(bus.o_state), 32'(IDLE));
  endtask

  initial begin
    i_rst_n      = 1'b0;
    bus.i_valid  = 1'b0;
    bus.i_bands  = '0;
    bus.i_cfg_we = 1'b0;
    bus.i_cfg    = '0;
    repeat (3) @(posedge i_clk);
    #1 check_idle_outputs("reset");
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);

    // Unity gain
    send(pack5(100, 200, 300, 400, 500), 16'd1500, 1'b0, 1, 1);
    drain();

    // Mixed gains: 1000*2 + 1000*4 + floor(-7/4) = 5998
    write_cfg(10'b00_00_11_10_01);
    send(pack5(1000, 1000, -7, 0, 0), 16'd5998, 1'b0, 1, 1);
    drain();

    // Positive and negative clipping
    write_cfg(10'b10_10_10_10_10);
    send(pack5(8000, 8000, 8000, 8000, 8000), 16'h7FFF, 1'b1, 1, 1);
    drain();
    send(pack5(-8192, -8192, -8192, -8192, -8192), 16'h8000, 1'b1, 1, 1);
    drain();

    // x2 wrap: 0x4000 << 1 = 0x8000 = -32768, in range so no clip
    write_cfg(10'b00_00_00_00_01);
    send(pack5(16'h4000, 0, 0, 0, 0), 16'h8000, 1'b0, 1, 1);
    drain();
    check("drop_before_overrun", 32'(bus.o_drop_cnt), 32'd0);

    // Overrun: valid held for the accept edge plus the 6 busy edges
    write_cfg(10'b0);
    send(pack5(1, 1, 1, 1, 1), 16'd5, 1'b0, 7, 1);
    drain();
    check("drop_six", 32'(bus.o_drop_cnt), 32'd6);
    for (int i = 0; i < 50; i++) begin
      send(pack5(1, 2, 3, 4, i), 16'(10 + i), 1'b0, 7, 1);
      drain();
    end
    check("drop_saturated", 32'(bus.o_drop_cnt), 32'd255);

    // Config write during RUN only affects the following sample
    send(pack5(100, 0, 0, 0, 0), 16'd100, 1'b0, 1, 1);
    write_cfg(10'b00_00_00_00_10);
    drain();
    send(pack5(100, 0, 0, 0, 0), 16'd400, 1'b0, 1, 1);
    drain();

    // Accept and config write in the same cycle: snapshot takes old config (x4)
    @(negedge i_clk);
    bus.i_valid  = 1'b1;
    bus.i_bands  = pack5(100, 0, 0, 0, 0);
    bus.i_cfg_we = 1'b1;
    bus.i_cfg    = 10'b0;
    exp_q.push_back({1'b0, 16'd400});
    lat_q.push_back(cyc + 7);
    @(posedge i_clk);
    #1 bus.i_valid = 1'b0;
    bus.i_cfg_we = 1'b0;
    drain();
    send(pack5(100, 0, 0, 0, 0), 16'd100, 1'b0, 1, 1);
    drain();

    // Reset during RUN: no result, everything cleared including config
    write_cfg(10'b00_00_00_00_10);
    send(pack5(100, 0, 0, 0, 0), 16'd0, 1'b0, 1, 0);
    repeat (2) @(posedge i_clk);
    #3 i_rst_n = 1'b0;
    #1 check_idle_outputs("midrun_reset");
    @(negedge i_clk);
    i_rst_n = 1'b1;
    repeat (12) @(negedge i_clk);
    send(pack5(100, 0, 0, 0, 0), 16'd100, 1'b0, 1, 1);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/band_gain_sched.md
Name: band_gain_sched

Overview:
Time-multiplexes one shared 2-bit amplifier (ampl_2bit) across the 5 FIR equalizer band outputs for each audio sample. It applies a per-band gain select, accumulates the scaled band samples and saturates the sum to 16 bits. The block sits between the 5-band FIR filter bank and the audio output path, and owns the per-band gain configuration registers.

Parameters:
NBANDS, 5, number of equalizer bands scheduled per sample
W, 16, sample width (signed two's complement)
ACC_W, 19, accumulator width; must be at least W+ceil(log2(NBANDS))

Ports:
i_clk  in  1  system clock
i_rst_n  in  1  asynchronous active-low reset
i_valid  in  1  sample strobe; i_bands holds all band samples for one sample period
i_bands  in  NBANDS*W  packed signed band samples; band k occupies bits [k*W +: W]
i_cfg_we  in  1  gain config write strobe
i_cfg  in  2*NBANDS  packed gain selects; band k occupies bits [2k +: 2]
o_ready  out  1  high when IDLE, i.e. when a new sample can be accepted
o_valid  out  1  one-cycle pulse; o_mix is valid
o_mix  out  W  saturated signed sum of the gain-scaled bands
o_sat  out  1  sum clipped this sample; qualified by o_valid
o_drop_cnt  out  8  saturating count of samples dropped because the block was busy

Behaviour:
- Reset (asynchronous, i_rst_n=0): FSM to IDLE; o_valid, o_mix, o_sat and o_drop_cnt are 0; o_ready is 1; gain config, shadow config and accumulator are 0 (all bands unity gain).
- Gain code per band, matching ampl_2bit:
  - 00 = x1.
  - 01 = x2: left shift, MSB discarded, result wraps.
  - 10 = x4: left shift by 2, wraps.
  - 11 = /4: arithmetic right shift, floors toward -inf.
- Config:
  - i_cfg_we loads the active config register on the next clock edge.
  - Config changes while a sample is in progress do not affect that sample.
- FSM IDLE:
  - i_valid=1 snapshots i_bands and the active config into working registers, clears the accumulator, sets band index to 0 and moves to RUN.
  - If i_valid and i_cfg_we are asserted in the same cycle, the snapshot takes the old config.
- FSM RUN:
  - One band per cycle: acc <= acc + sext(amp_out of band[idx], ACC_W) and idx increments.
  - After band NBANDS-1 the FSM moves to DONE.
- FSM DONE:
  - acc > 2^(W-1)-1: o_mix = 32767 and o_sat = 1.
  - acc < -2^(W-1): o_mix = -32768 and o_sat = 1.
  - Otherwise o_mix = acc[W-1:0] and o_sat = 0.
  - o_valid pulses for 1 cycle, then the FSM returns to IDLE.
  - o_mix and o_sat hold until the next DONE.
- Latency: i_valid accepted at edge T gives o_valid high in the cycle after edge T+NBANDS+1, i.e. 7 cycles for NBANDS=5. Throughput is one sample per NBANDS+2 cycles.
- Overrun: i_valid while not IDLE drops the sample and increments o_drop_cnt; o_drop_cnt saturates at 255. The in-progress sample is unaffected.
- i_valid in the DONE cycle is also dropped. i_valid in the cycle after DONE (IDLE) is accepted.
- Reset mid-operation discards the partial sum. No o_valid is issued for the aborted sample.

Decomposition:
- Shared package eq_pkg:
  - NBANDS and W constants.
  - Gain code constants GAIN_X1=2'b00, GAIN_X2=2'b01, GAIN_X4=2'b10, GAIN_DIV4=2'b11.
  - FSM state encoding IDLE/RUN/DONE.
- Sub-module: a single ampl_2bit instance fed by the band mux (band[idx], cfg[idx]). No other sub-modules.

Test Plan:
- All gains 00, bands = {100,200,300,400,500} -> o_valid 7 cycles after accept, o_mix=1500, o_sat=0.
- Gains {01,10,11,00,00}, bands = {1000,1000,-7,0,0} -> 2000+4000+(-2)+0+0, o_mix=5998.
- All gains 10, all bands 8000 -> acc=160000, o_mix=32767, o_sat=1. All bands -8192 with gain 10 -> o_mix=-32768, o_sat=1.
- Wrap case: band0 = 0x4000 with gain 01 -> contributes -32768; others 0 -> o_mix=-32768, o_sat=0.
- i_valid on each of the 6 cycles following an accept -> 6 drops, o_drop_cnt=6, first result correct. Then 300 overruns -> o_drop_cnt=255.
- i_cfg_we during RUN changing band0 from 00 to 10 -> current sample uses x1, next sample uses x4. Reset asserted in RUN -> no o_valid, outputs 0, o_ready=1.
